// File: rtl/power_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : power_ctrl_pkg
// Purpose  : Shared state encoding and state-group decode helpers for the
//            multi-domain power-shut-off sequencer.
// Revision : 1.0  initial release
// ============================================================================
package power_ctrl_pkg;

  // 4-bit state encoding; values are fixed so that the state groups below
  // can be decoded as contiguous ranges.
  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_CLK_OFF = 4'd1;
  localparam state_t ST_WAIT1   = 4'd2;
  localparam state_t ST_ISOLATE = 4'd3;
  localparam state_t ST_SAVE    = 4'd4;
  localparam state_t ST_PRE_OFF = 4'd5;
  localparam state_t ST_OFF     = 4'd6;
  localparam state_t ST_PWR_REQ = 4'd7;
  localparam state_t ST_PWR_ON1 = 4'd8;
  localparam state_t ST_PWR_ON2 = 4'd9;
  localparam state_t ST_RESTORE = 4'd10;
  localparam state_t ST_WAIT2   = 4'd11;
  localparam state_t ST_DE_ISO  = 4'd12;
  localparam state_t ST_CLK_ON  = 4'd13;
  localparam state_t ST_WAIT3   = 4'd14;
  localparam state_t ST_RST_CLR = 4'd15;

  // Domain clock is gated from CLK_OFF up to and including DE_ISO.
  function automatic logic st_gated(input state_t s);
    return (s >= ST_CLK_OFF) && (s <= ST_DE_ISO);
  endfunction

  // Domain outputs are clamped from ISOLATE up to and including WAIT2.
  function automatic logic st_isolated(input state_t s);
    return (s >= ST_ISOLATE) && (s <= ST_WAIT2);
  endfunction

  // Non-retention flops are held in reset from OFF up to and including WAIT3.
  function automatic logic st_rstn_low(input state_t s);
    return (s >= ST_OFF) && (s <= ST_WAIT3);
  endfunction

  // Weak switch is open only while fully off or waiting for an inrush slot.
  function automatic logic st_pwr1_off(input state_t s);
    return (s == ST_OFF) || (s == ST_PWR_REQ);
  endfunction

  // Strong switch additionally stays open during the stagger phase.
  function automatic logic st_pwr2_off(input state_t s);
    return (s == ST_OFF) || (s == ST_PWR_REQ) || (s == ST_PWR_ON1);
  endfunction

  // States that own the shared inrush grant.
  function automatic logic st_inrush(input state_t s);
    return (s == ST_PWR_ON1) || (s == ST_PWR_ON2);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/power_ctrl_dom_fsm.sv
`default_nettype none
// ============================================================================
// Module   : power_ctrl_dom_fsm
// Purpose  : Single power domain sequencer: clock gate, isolate, save,
//            power-off, staged power-on, restore and release.
//            Optional macro PWR_CTRL_EARLY_ABORT_EN: dropping the request in
//            CLK_OFF/WAIT1 short-circuits to CLK_ON.
// Revision : 1.0  initial release
// ============================================================================
module power_ctrl_dom_fsm
  import power_ctrl_pkg::*;
#(
  parameter int PWR_STAGGER  = 2,
  parameter int RESTORE_WAIT = 28
) (
  input  logic pclk,
  input  logic nprst,
  input  logic l1_req_i,
  input  logic grant_i,
  output logic req_o,
  output logic hold_d_o,
  output logic set_status_o,
  output logic clr_status_o,
  output logic rstn_non_srpg_o,
  output logic gate_clk_o,
  output logic isolate_o,
  output logic save_edge_o,
  output logic restore_edge_o,
  output logic pwr1_on_o,
  output logic pwr2_on_o
);

  localparam int CNT_W = $clog2(max2(PWR_STAGGER, RESTORE_WAIT) + 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(PWR_STAGGER - 1);
  localparam logic [CNT_W-1:0] RESTORE_LOAD = CNT_W'(RESTORE_WAIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_q, iso_q, save_q, restore_q, pwr1_q, pwr2_q, rstn_reg_q;

  // Next-state decode; l1_req only matters in IDLE and OFF (and CLK_OFF/WAIT1
  // when early abort is built in).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (l1_req_i) state_d = ST_CLK_OFF;
      ST_CLK_OFF: begin
        state_d = ST_WAIT1;
`ifdef PWR_CTRL_EARLY_ABORT_EN
        if (!l1_req_i) state_d = ST_CLK_ON;
`endif
      end
      ST_WAIT1:   begin
        state_d = ST_ISOLATE;
`ifdef PWR_CTRL_EARLY_ABORT_EN
        if (!l1_req_i) state_d = ST_CLK_ON;
`endif
      end
      ST_ISOLATE: state_d = ST_SAVE;
      ST_SAVE:    state_d = ST_PRE_OFF;
      ST_PRE_OFF: state_d = ST_OFF;
      ST_OFF:     if (!l1_req_i) state_d = ST_PWR_REQ;
      ST_PWR_REQ: if (grant_i) state_d = ST_PWR_ON1;
      ST_PWR_ON1: if (cnt_q == '0) state_d = ST_PWR_ON2;
      ST_PWR_ON2: if (cnt_q == '0) state_d = ST_RESTORE;
      ST_RESTORE: state_d = ST_WAIT2;
      ST_WAIT2:   state_d = ST_DE_ISO;
      ST_DE_ISO:  state_d = ST_CLK_ON;
      ST_CLK_ON:  state_d = ST_WAIT3;
      ST_WAIT3:   state_d = ST_RST_CLR;
      ST_RST_CLR: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Dwell counter: loaded on entry to a timed state, counts down to zero
  // while there, and is forced to zero everywhere else.
  always_comb begin
    cnt_d = '0;
    if (state_d == ST_PWR_ON1 && state_q != ST_PWR_ON1) begin
      cnt_d = STAGGER_LOAD;
    end else if (state_d == ST_PWR_ON2 && state_q != ST_PWR_ON2) begin
      cnt_d = RESTORE_LOAD;
    end else if (st_inrush(state_q) && state_d == state_q && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State, counter and next-state-registered domain controls.
  always_ff @(posedge pclk) begin
    if (!nprst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gate_q     <= 1'b0;
      iso_q      <= 1'b0;
      save_q     <= 1'b0;
      restore_q  <= 1'b0;
      pwr1_q     <= 1'b1;
      pwr2_q     <= 1'b1;
      rstn_reg_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gate_q     <= st_gated(state_d);
      iso_q      <= st_isolated(state_d);
      save_q     <= (state_d == ST_SAVE);
      restore_q  <= (state_d == ST_RESTORE);
      pwr1_q     <= !st_pwr1_off(state_d);
      pwr2_q     <= !st_pwr2_off(state_d);
      rstn_reg_q <= !st_rstn_low(state_d);
    end
  end

  assign req_o    = (state_q == ST_PWR_REQ);
  assign hold_d_o = st_inrush(state_d);

  // Status pulses are suppressed while the block itself is held in reset.
  assign set_status_o = nprst && (state_q == ST_IDLE) && (state_d == ST_CLK_OFF);
  assign clr_status_o = nprst && (state_q == ST_RST_CLR);

  assign rstn_non_srpg_o = rstn_reg_q & nprst;
  assign gate_clk_o      = gate_q;
  assign isolate_o       = iso_q;
  assign save_edge_o     = save_q;
  assign restore_edge_o  = restore_q;
  assign pwr1_on_o       = pwr1_q;
  assign pwr2_on_o       = pwr2_q;

endmodule
`default_nettype wire

// File: rtl/power_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : power_ctrl_seq
// Purpose  : Multi-domain power-shut-off sequencer. One FSM per domain plus a
//            round-robin arbiter that admits one domain at a time into the
//            power-up inrush phase (PWR_ON1/PWR_ON2).
//            Optional macro PWR_CTRL_EARLY_ABORT_EN (see power_ctrl_dom_fsm).
// Revision : 1.0  initial release
// ============================================================================
module power_ctrl_seq
  import power_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS  = 2,
  parameter int PWR_STAGGER  = 2,
  parameter int RESTORE_WAIT = 28
) (
  input  logic                   pclk,
  input  logic                   nprst,
  input  logic [NUM_DOMAINS-1:0] l1_req,
  output logic [NUM_DOMAINS-1:0] set_status,
  output logic [NUM_DOMAINS-1:0] clr_status,
  output logic [NUM_DOMAINS-1:0] rstn_non_srpg,
  output logic [NUM_DOMAINS-1:0] gate_clk,
  output logic [NUM_DOMAINS-1:0] isolate,
  output logic [NUM_DOMAINS-1:0] save_edge,
  output logic [NUM_DOMAINS-1:0] restore_edge,
  output logic [NUM_DOMAINS-1:0] pwr1_on,
  output logic [NUM_DOMAINS-1:0] pwr2_on
);

  localparam int PTR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic [NUM_DOMAINS-1:0] req;
  logic [NUM_DOMAINS-1:0] hold_d;
  logic [NUM_DOMAINS-1:0] grant_q;
  logic [NUM_DOMAINS-1:0] grant_new;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   busy;
  int                     best_dist;
  int                     winner;

  // Round-robin pick among PWR_REQ domains, only while no domain holds the
  // inrush grant. The pointer only advances when several domains contend.
  always_comb begin
    busy      = |grant_q;
    best_dist = NUM_DOMAINS;
    winner    = 0;
    grant_new = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (req[i] && (((i + NUM_DOMAINS - int'(rr_ptr_q)) % NUM_DOMAINS) < best_dist)) begin
        best_dist = (i + NUM_DOMAINS - int'(rr_ptr_q)) % NUM_DOMAINS;
        winner    = i;
      end
    end
    if (!busy && best_dist < NUM_DOMAINS) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        grant_new[i] = (winner == i);
      end
      if ($countones(req) > 1) begin
        rr_ptr_d = PTR_W'((winner + 1) % NUM_DOMAINS);
      end
    end
  end

  // Grant vector follows each domain's inrush occupancy; pointer register.
  always_ff @(posedge pclk) begin
    if (!nprst) begin
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      grant_q  <= hold_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    power_ctrl_dom_fsm #(
      .PWR_STAGGER  (PWR_STAGGER),
      .RESTORE_WAIT (RESTORE_WAIT)
    ) u_dom (
      .pclk            (pclk),
      .nprst           (nprst),
      .l1_req_i        (l1_req[g]),
      .grant_i         (grant_new[g]),
      .req_o           (req[g]),
      .hold_d_o        (hold_d[g]),
      .set_status_o    (set_status[g]),
      .clr_status_o    (clr_status[g]),
      .rstn_non_srpg_o (rstn_non_srpg[g]),
      .gate_clk_o      (gate_clk[g]),
      .isolate_o       (isolate[g]),
      .save_edge_o     (save_edge[g]),
      .restore_edge_o  (restore_edge[g]),
      .pwr1_on_o       (pwr1_on[g]),
      .pwr2_on_o       (pwr2_on[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_power_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_power_ctrl_seq
// Purpose  : Self-checking bench for power_ctrl_seq (2 domains, stagger 2,
//            restore wait 28). Honours PWR_CTRL_EARLY_ABORT_EN if defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_power_ctrl_seq;

  localparam int N = 2;

  localparam int S_GATE = 0, S_ISO = 1, S_SAVE = 2, S_REST = 3, S_PWR1 = 4,
                 S_PWR2 = 5, S_RSTN = 6, S_SET = 7, S_CLR = 8;

  logic         pclk = 1'b0;
  logic         nprst;
  logic [N-1:0] l1_req;
  logic [N-1:0] set_status, clr_status, rstn_non_srpg, gate_clk, isolate;
  logic [N-1:0] save_edge, restore_edge, pwr1_on, pwr2_on;

  power_ctrl_seq #(.NUM_DOMAINS(N), .PWR_STAGGER(2), .RESTORE_WAIT(28)) dut (
    .pclk          (pclk),
    .nprst         (nprst),
    .l1_req        (l1_req),
    .set_status    (set_status),
    .clr_status    (clr_status),
    .rstn_non_srpg (rstn_non_srpg),
    .gate_clk      (gate_clk),
    .isolate       (isolate),
    .save_edge     (save_edge),
    .restore_edge  (restore_edge),
    .pwr1_on       (pwr1_on),
    .pwr2_on       (pwr2_on)
  );

  always #5 pclk = ~pclk;

  int edge_cnt = 0;
  always @(posedge pclk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int           cyc;
    int           sel;
    logic [N-1:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] sig(input int sel);
    case (sel)
      S_GATE:  return gate_clk;
      S_ISO:   return isolate;
      S_SAVE:  return save_edge;
      S_REST:  return restore_edge;
      S_PWR1:  return pwr1_on;
      S_PWR2:  return pwr2_on;
      S_RSTN:  return rstn_non_srpg;
      S_SET:   return set_status;
      default: return clr_status;
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      S_GATE:  return "gate_clk";
      S_ISO:   return "isolate";
      S_SAVE:  return "save_edge";
      S_REST:  return "restore_edge";
      S_PWR1:  return "pwr1_on";
      S_PWR2:  return "pwr2_on";
      S_RSTN:  return "rstn_non_srpg";
      S_SET:   return "set_status";
      default: return "clr_status";
    endcase
  endfunction

  task automatic expect_at(input int cyc, input int sel, input logic [N-1:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  // Output monitor: status exclusivity every cycle, plus any scoreboard
  // entries that fall due after the edge just taken.
  always @(negedge pclk) begin
    chk_eq("set_clr_excl", 32'(set_status & clr_status), 32'd0);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edge_cnt) begin
        chk_eq($sformatf("%s@%0d", sig_name(sb[i].sel), sb[i].cyc),
               32'(sig(sb[i].sel)), 32'(sb[i].val));
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (edge_cnt < t) step();
  endtask

  int b;

  initial begin
    nprst  = 1'b0;
    l1_req = '0;

    // Reset values
    expect_at(1, S_GATE, 2'b00); expect_at(1, S_ISO, 2'b00);
    expect_at(1, S_SAVE, 2'b00); expect_at(1, S_REST, 2'b00);
    expect_at(1, S_PWR1, 2'b11); expect_at(1, S_PWR2, 2'b11);
    expect_at(1, S_RSTN, 2'b00);
    expect_at(3, S_RSTN, 2'b11);
    wait_to(2);
    nprst = 1'b1;
    wait_to(4);

    // Test 1: full single-domain sequence
    b = edge_cnt;
    l1_req = 2'b01;
    expect_at(b,      S_SET,  2'b01);
    expect_at(b + 1,  S_GATE, 2'b01); expect_at(b + 1, S_SET, 2'b00);
    expect_at(b + 2,  S_ISO,  2'b00);
    expect_at(b + 3,  S_ISO,  2'b01);
    expect_at(b + 4,  S_SAVE, 2'b01); expect_at(b + 5, S_SAVE, 2'b00);
    expect_at(b + 5,  S_PWR1, 2'b11);
    expect_at(b + 6,  S_PWR1, 2'b10); expect_at(b + 6, S_PWR2, 2'b10);
    expect_at(b + 6,  S_RSTN, 2'b10);
    expect_at(b + 21, S_PWR1, 2'b10);
    expect_at(b + 22, S_PWR1, 2'b11); expect_at(b + 23, S_PWR2, 2'b10);
    expect_at(b + 24, S_PWR2, 2'b11);
    expect_at(b + 51, S_REST, 2'b00); expect_at(b + 52, S_REST, 2'b01);
    expect_at(b + 53, S_REST, 2'b00); expect_at(b + 53, S_ISO, 2'b01);
    expect_at(b + 54, S_ISO,  2'b00); expect_at(b + 54, S_GATE, 2'b01);
    expect_at(b + 55, S_GATE, 2'b00);
    expect_at(b + 56, S_RSTN, 2'b10); expect_at(b + 56, S_CLR, 2'b00);
    expect_at(b + 57, S_RSTN, 2'b11); expect_at(b + 57, S_CLR, 2'b01);
    expect_at(b + 58, S_CLR,  2'b00);
    wait_to(b + 20);
    l1_req = 2'b00;
    wait_to(b + 60);

    // Test 2: reset while domain 0 sits in PWR_ON2
    b = edge_cnt;
    l1_req = 2'b01;
    expect_at(b + 11, S_PWR2, 2'b11);
    expect_at(b + 15, S_ISO,  2'b01);
    expect_at(b + 16, S_ISO,  2'b00); expect_at(b + 16, S_GATE, 2'b00);
    expect_at(b + 16, S_PWR1, 2'b11); expect_at(b + 16, S_PWR2, 2'b11);
    expect_at(b + 16, S_RSTN, 2'b00); expect_at(b + 16, S_REST, 2'b00);
    expect_at(b + 18, S_RSTN, 2'b11); expect_at(b + 18, S_ISO, 2'b00);
    wait_to(b + 7);
    l1_req = 2'b00;
    wait_to(b + 15);
    nprst = 1'b0;
    wait_to(b + 17);
    nprst = 1'b1;
    wait_to(b + 20);

    // Test 3: contention, then the next contention favours domain 1
    b = edge_cnt;
    l1_req = 2'b11;
    expect_at(b + 6,  S_PWR1, 2'b00);
    expect_at(b + 11, S_PWR1, 2'b00);
    expect_at(b + 12, S_PWR1, 2'b01);
    expect_at(b + 14, S_PWR2, 2'b01);
    expect_at(b + 42, S_REST, 2'b01); expect_at(b + 42, S_PWR1, 2'b01);
    expect_at(b + 43, S_PWR1, 2'b11);
    expect_at(b + 45, S_PWR2, 2'b11);
    expect_at(b + 47, S_CLR,  2'b01);
    expect_at(b + 73, S_REST, 2'b10);
    expect_at(b + 78, S_CLR,  2'b10);
    wait_to(b + 10);
    l1_req = 2'b00;
    wait_to(b + 80);

    b = edge_cnt;
    l1_req = 2'b11;
    expect_at(b + 11, S_PWR1, 2'b00);
    expect_at(b + 12, S_PWR1, 2'b10);
    expect_at(b + 42, S_REST, 2'b10);
    expect_at(b + 43, S_PWR1, 2'b11);
    expect_at(b + 78, S_CLR,  2'b01);
    wait_to(b + 10);
    l1_req = 2'b00;
    wait_to(b + 80);

    // Test 4: one-cycle request pulse
    b = edge_cnt;
    l1_req = 2'b01;
    expect_at(b + 1, S_GATE, 2'b01);
`ifdef PWR_CTRL_EARLY_ABORT_EN
    expect_at(b + 2, S_GATE, 2'b00); expect_at(b + 2, S_ISO, 2'b00);
    expect_at(b + 3, S_ISO,  2'b00);
    expect_at(b + 4, S_CLR,  2'b01); expect_at(b + 5, S_CLR, 2'b00);
`else
    expect_at(b + 2, S_GATE, 2'b01);
    expect_at(b + 3, S_ISO,  2'b01);
    expect_at(b + 6, S_PWR1, 2'b10);
    expect_at(b + 43, S_CLR, 2'b01);
`endif
    step();
    l1_req = 2'b00;
    wait_to(b + 48);

    // Test 5: request held through OFF, ignored during PWR_ON2,
    // and still high at RST_CLR
    b = edge_cnt;
    l1_req = 2'b01;
    expect_at(b + 29, S_PWR1, 2'b10);
    expect_at(b + 31, S_PWR1, 2'b10);
    expect_at(b + 32, S_PWR1, 2'b11);
    expect_at(b + 40, S_SET,  2'b00);
    expect_at(b + 41, S_ISO,  2'b01);
    expect_at(b + 62, S_REST, 2'b01);
    expect_at(b + 67, S_CLR,  2'b01); expect_at(b + 67, S_SET, 2'b00);
    expect_at(b + 68, S_SET,  2'b01); expect_at(b + 68, S_GATE, 2'b00);
    expect_at(b + 69, S_GATE, 2'b01);
    expect_at(b + 74, S_PWR1, 2'b10);
    expect_at(b + 111, S_CLR, 2'b01);
    wait_to(b + 30);
    l1_req = 2'b00;
    wait_to(b + 40);
    l1_req = 2'b01;
    step();
    l1_req = 2'b00;
    wait_to(b + 65);
    l1_req = 2'b01;
    wait_to(b + 71);
    l1_req = 2'b00;
    wait_to(b + 114);

    chk_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
